uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 75 +++++++
 rtl/uart_tick_detect.sv | 37 +++
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   - tx_state_t / ST_*      : transmitter FSM state encoding
//   - parity_mode_t / PAR_*  : parity_mode port encoding
//   - baud_code_t / BAUD_*   : bitrate codes understood by the upstream
//                              bitrate generator, plus the counter_final
//                              value each one loads (bit time is
//                              2*(counter_final+1) clk_CPU cycles)
//   - frame_cfg_t            : per-frame options latched at acceptance
// -----------------------------------------------------------------------------
package uart_pkg;

    // Transmitter FSM states, kept as plain constants for encoding
    // compatibility with existing register dumps.
    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_ARM    = 3'd1;
    localparam tx_state_t ST_START  = 3'd2;
    localparam tx_state_t ST_DATA   = 3'd3;
    localparam tx_state_t ST_PARITY = 3'd4;
    localparam tx_state_t ST_STOP   = 3'd5;

    // parity_mode encoding; 2'b11 is reserved and behaves as no parity.
    typedef logic [1:0] parity_mode_t;

    localparam parity_mode_t PAR_NONE = 2'b00;
    localparam parity_mode_t PAR_EVEN = 2'b01;
    localparam parity_mode_t PAR_ODD  = 2'b10;
    localparam parity_mode_t PAR_RSVD = 2'b11;

    // Bitrate codes of the upstream generator. The generator toggles
    // uart_clock every counter_final+1 cycles, so one rising edge of
    // uart_clock (one tick) appears every 2*(counter_final+1) cycles.
    typedef logic [3:0] baud_code_t;

    localparam baud_code_t BAUD_CODE_0000 = 4'b0000;
    localparam baud_code_t BAUD_CODE_0001 = 4'b0001;
    localparam baud_code_t BAUD_CODE_0010 = 4'b0010;
    localparam baud_code_t BAUD_CODE_0011 = 4'b0011;
    localparam baud_code_t BAUD_CODE_0100 = 4'b0100;
    localparam baud_code_t BAUD_CODE_0101 = 4'b0101;
    localparam baud_code_t BAUD_CODE_0110 = 4'b0110;
    localparam baud_code_t BAUD_CODE_0111 = 4'b0111;

    localparam int unsigned BAUD_CNT_W = 16;

    function automatic logic [BAUD_CNT_W-1:0] baud_counter_final(input baud_code_t code);
        logic [BAUD_CNT_W-1:0] cf;
        case (code)
            BAUD_CODE_0000: cf = 16'd4;
            BAUD_CODE_0001: cf = 16'd9;
            BAUD_CODE_0010: cf = 16'd20;
            BAUD_CODE_0011: cf = 16'd41;
            BAUD_CODE_0100: cf = 16'd83;
            BAUD_CODE_0101: cf = 16'd167;
            BAUD_CODE_0110: cf = 16'd335;
            BAUD_CODE_0111: cf = 16'd671;
            default:        cf = 16'd20;
        endcase
        return cf;
    endfunction

    // Frame options captured together with the payload on acceptance.
    typedef struct packed {
        parity_mode_t parity_mode;
        logic         stop2;
    } frame_cfg_t;

    function automatic logic parity_enabled(input parity_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tick_detect.sv
// -----------------------------------------------------------------------------
// uart_tick_detect
// Turns the upstream uart_clock level into a one-cycle tick on its rising
// edge. uart_clock is produced in the clk_CPU domain, so no synchronizer.
//
// Ports
//   clk_CPU    in  system clock, rising edge
//   RST_TX     in  synchronous active-high reset (clears edge history)
//   EN         in  enable; tick is suppressed while low
//   uart_clock in  bit clock from the bitrate generator
//   tick       out one-cycle pulse: uart_clock=1 and previous sample=0
// -----------------------------------------------------------------------------
module uart_tick_detect
    import uart_pkg::*;
(
    input  logic clk_CPU,
    input  logic RST_TX,
    input  logic EN,
    input  logic uart_clock,
    output logic tick
);

    logic uart_clock_q;

    // History follows uart_clock even while disabled, so an edge that
    // happened during EN=0 is dropped instead of firing on re-enable.
    always_ff @(posedge clk_CPU) begin
        if (RST_TX) begin
            uart_clock_q <= 1'b0;
        end else begin
            uart_clock_q <= uart_clock;
        end
    end

    assign tick = EN & uart_clock & ~uart_clock_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. A request is accepted in IDLE, the frame is then
// aligned to the next bit tick and shifted out LSB first:
//   start(0), DATA_W data bits, optional parity, one or two stop bits(1).
//
// Parameters
//   DATA_W      payload bits per frame (5..8)
//
// Ports
//   clk_CPU     in  system clock, rising edge
//   RST_TX      in  synchronous active-high reset, aborts any frame
//   EN          in  enable; low freezes state, counters and tx
//   uart_clock  in  bit clock from the upstream bitrate generator
//   tx_data     in  payload, latched on acceptance
//   tx_start    in  request, accepted only when tx_ready=1 and EN=1
//   parity_mode in  00 none, 01 even, 10 odd, 11 none
//   stop2       in  0: one stop bit, 1: two stop bits
//   tx          out registered serial line, idle high
//   tx_ready    out high only in IDLE
//   tx_busy     out inverse of tx_ready
//   tx_done     out one-cycle pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_CPU,
    input  logic              RST_TX,
    input  logic              EN,
    input  logic              uart_clock,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_start,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              tx,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] data_q;
    frame_cfg_t        cfg_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              stop_second;
    logic              tick;
    logic              parity_bit;

    uart_tick_detect u_tick_detect (
        .clk_CPU    (clk_CPU),
        .RST_TX     (RST_TX),
        .EN         (EN),
        .uart_clock (uart_clock),
        .tick       (tick)
    );

    // Even parity makes the total count of ones even; odd inverts it.
    always_comb begin
        parity_bit = (^data_q) ^ (cfg_q.parity_mode == PAR_ODD);
    end

    // Only used while bit_cnt < LAST_BIT, so it never leaves 0..DATA_W-1.
    always_comb begin
        next_cnt = bit_cnt + 1'b1;
    end

    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = ~tx_ready;

    // tx is updated on the same edge that consumes the tick, so each new
    // bit becomes visible one cycle after the tick is seen.
    always_ff @(posedge clk_CPU) begin
        if (RST_TX) begin
            state       <= ST_IDLE;
            tx          <= 1'b1;
            tx_done     <= 1'b0;
            data_q      <= '0;
            cfg_q       <= '0;
            bit_cnt     <= '0;
            stop_second <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (EN) begin
                case (state)
                    ST_IDLE: begin
                        tx <= 1'b1;
                        // A tick in this same cycle is not used: the frame
                        // waits in ARM for the next one.
                        if (tx_start) begin
                            data_q            <= tx_data;
                            cfg_q.parity_mode <= parity_mode;
                            cfg_q.stop2       <= stop2;
                            state             <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (tick) begin
                            tx    <= 1'b0;
                            state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            tx      <= data_q[0];
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            if (bit_cnt < LAST_BIT) begin
                                bit_cnt <= next_cnt;
                                tx      <= data_q[next_cnt];
                            end else if (parity_enabled(cfg_q.parity_mode)) begin
                                tx    <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx          <= 1'b1;
                                stop_second <= 1'b0;
                                state       <= ST_STOP;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (tick) begin
                            tx          <= 1'b1;
                            stop_second <= 1'b0;
                            state       <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (tick) begin
                            if (cfg_q.stop2 && !stop_second) begin
                                stop_second <= 1'b1;
                            end else begin
                                tx      <= 1'b1;
                                tx_done <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Drives uart_tx with a bitrate-code-0010 uart_clock (toggle every 21 cycles,
// 42-cycle bit) and checks each frame against a model built from the frame
// rules: expected bit list, and the line advancing one bit per enabled
// uart_clock rising edge after acceptance.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int MAXC     = 40000;
    localparam int HALF_BIT = 21;

    logic       clk_CPU    = 1'b0;
    logic       uart_clock = 1'b0;
    logic       RST_TX;
    logic       EN;
    logic       tx_start;
    logic       stop2;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;

    int cyc    = 0;
    int bcnt   = 0;
    int checks = 0;
    int errors = 0;

    logic uc_l   [MAXC];
    logic en_l   [MAXC];
    logic rst_l  [MAXC];
    logic tx_l   [MAXC];
    logic rdy_l  [MAXC];
    logic busy_l [MAXC];
    logic done_l [MAXC];

    uart_tx #(.DATA_W(8)) dut (
        .clk_CPU     (clk_CPU),
        .RST_TX      (RST_TX),
        .EN          (EN),
        .uart_clock  (uart_clock),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx          (tx),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    initial forever #5 clk_CPU = ~clk_CPU;

    // Upstream bitrate generator for code 0010 (counter_final = 20).
    always @(negedge clk_CPU) begin
        if (bcnt == HALF_BIT - 1) begin
            bcnt       <= 0;
            uart_clock <= ~uart_clock;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    // Inputs as seen at posedge k.
    always @(posedge clk_CPU) begin
        if (cyc < MAXC) begin
            uc_l[cyc]  <= uart_clock;
            en_l[cyc]  <= EN;
            rst_l[cyc] <= RST_TX;
        end
        cyc <= cyc + 1;
    end

    // Outputs produced by posedge k, sampled on the following negedge.
    always @(negedge clk_CPU) begin
        if (cyc > 0 && cyc <= MAXC) begin
            tx_l[cyc-1]   <= tx;
            rdy_l[cyc-1]  <= tx_ready;
            busy_l[cyc-1] <= tx_busy;
            done_l[cyc-1] <= tx_done;
        end
    end

    // Enabled rising edge of uart_clock at posedge k; edge history is
    // cleared by reset.
    function automatic bit is_tick(input int k);
        logic prev;
        if (k < 1) return 1'b0;
        prev = rst_l[k-1] ? 1'b0 : uc_l[k-1];
        return !rst_l[k] && en_l[k] && uc_l[k] && !prev;
    endfunction

    // {tx,ready,busy,done} if constant over [lo,hi], else all-x.
    function automatic logic [3:0] seg_val(input int lo, input int hi);
        logic [3:0] v;
        if (lo > hi) return 4'bxxxx;
        v = {tx_l[lo], rdy_l[lo], busy_l[lo], done_l[lo]};
        for (int i = lo + 1; i <= hi; i++) begin
            if ({tx_l[i], rdy_l[i], busy_l[i], done_l[i]} !== v) return 4'bxxxx;
        end
        return v;
    endfunction

    task automatic chk(input logic [3:0] obs, input logic [3:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed {tx,ready,busy,done}=%b expected %b", tag, obs, expv);
        end
    endtask

    // mode: 0 plain, 1 tx_start 0xFF mid-frame, 2 EN low 100 cycles,
    //       3 RST_TX pulse during data bit 3
    task automatic run_frame(input logic [7:0] d, input logic [1:0] pm,
                             input logic s2, input int mode, input string tag);
        logic exp_bits[$];
        int   tk[$];
        int   a, e, nb, win, ntk, t5, rst_c, gap, lim, lo, hi;
        exp_bits = {};
        tk       = {};
        exp_bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
        if (pm == 2'b01) exp_bits.push_back(^d);
        if (pm == 2'b10) exp_bits.push_back(~^d);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
        nb  = exp_bits.size();
        win = 2 * HALF_BIT * (nb + 3) + ((mode == 2) ? 100 : 0) + 40;

        @(negedge clk_CPU);
        tx_data     = d;
        parity_mode = pm;
        stop2       = s2;
        tx_start    = 1'b1;
        a     = cyc;
        ntk   = 0;
        t5    = -1;
        rst_c = -1;
        gap   = 0;
        for (int n = 0; n < win; n++) begin
            @(negedge clk_CPU);
            if ((cyc - 1) > a && rst_c < 0 && is_tick(cyc - 1)) begin
                ntk++;
                if (ntk == 5) t5 = cyc - 1;
            end
            tx_start    = 1'b0;
            RST_TX      = 1'b0;
            tx_data     = 8'($urandom);
            parity_mode = 2'($urandom);
            stop2       = 1'($urandom);
            if (mode == 1 && n == 200) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end
            if (mode == 2 && n == 250) gap = 100;
            if (gap > 0) begin
                EN = 1'b0;
                gap--;
            end else begin
                EN = 1'b1;
            end
            if (mode == 3 && rst_c < 0 && t5 >= 0 && (cyc - 1) == t5 + 10) begin
                RST_TX = 1'b1;
                rst_c  = cyc;
            end
        end
        tx_start = 1'b0;
        RST_TX   = 1'b0;
        EN       = 1'b1;
        @(negedge clk_CPU);
        #1;
        e = a + win - 1;

        for (int k = a + 1; k <= e; k++) begin
            if (rst_c >= 0 && k >= rst_c) break;
            if (is_tick(k)) tk.push_back(k);
        end
        lim = (rst_c >= 0) ? rst_c - 1 : e;

        hi = (tk.size() > 0) ? tk[0] - 1 : lim;
        chk(seg_val(a, hi), 4'b1010, $sformatf("%s wait_tick", tag));
        for (int j = 1; j <= nb && j <= tk.size(); j++) begin
            lo = tk[j-1];
            hi = (j < tk.size()) ? tk[j] - 1 : lim;
            chk(seg_val(lo, hi), {exp_bits[j-1], 3'b010}, $sformatf("%s bit%0d", tag, j - 1));
        end
        if (rst_c >= 0) begin
            chk(seg_val(rst_c, e), 4'b1100, $sformatf("%s after_reset", tag));
        end else if (tk.size() < nb + 1) begin
            errors++;
            $error("FAIL %s window: observed %0d ticks expected at least %0d", tag, tk.size(), nb + 1);
        end else begin
            chk(seg_val(tk[nb], tk[nb]), 4'b1101, $sformatf("%s done_pulse", tag));
            chk(seg_val(tk[nb] + 1, e), 4'b1100, $sformatf("%s idle_after", tag));
        end
    endtask

    initial begin
        int c0;
        RST_TX      = 1'b1;
        EN          = 1'b1;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        repeat (5) @(negedge clk_CPU);
        RST_TX = 1'b0;
        @(negedge clk_CPU);
        #1;
        chk(seg_val(0, 4), 4'b1100, "reset_state");

        // Request while disabled must not be accepted.
        @(negedge clk_CPU);
        EN       = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'h00;
        c0       = cyc;
        repeat (30) @(negedge clk_CPU);
        tx_start = 1'b0;
        EN       = 1'b1;
        repeat (40) @(negedge clk_CPU);
        #1;
        chk(seg_val(c0, c0 + 60), 4'b1100, "en_low_start_ignored");

        run_frame(8'h55, 2'b00, 1'b0, 0, "f55_none");
        run_frame(8'h07, 2'b01, 1'b0, 0, "f07_even");
        run_frame(8'h07, 2'b10, 1'b0, 0, "f07_odd");
        run_frame(8'hA3, 2'b00, 1'b1, 0, "stop2");
        run_frame(8'h3C, 2'b01, 1'b0, 1, "midstart_ignored");
        run_frame(8'hC6, 2'b00, 1'b0, 3, "reset_bit3");
        run_frame(8'h9A, 2'b00, 1'b0, 0, "after_reset");
        run_frame(8'h5B, 2'b10, 1'b1, 2, "en_gap");

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk_CPU);
            run_frame(8'($urandom), 2'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
